wdt32_core: RTL and testbench

//  32-bit watchdog timer core; sits directly behind the APB_WDT32 register wrapper.

---
 rtl/wdt32_pkg.sv | 17 +
 rtl/wdt32_if.sv | 33 +++
 rtl/wdt32_prescaler.sv | 36 +++
 rtl/wdt32_core.sv | 103 ++++++++++
 tb/tb_wdt32_core.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/wdt32_pkg.sv
// Shared constants and state encoding for the wdt32 watchdog slice.
package wdt32_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } wdt32_state_e;

  localparam int unsigned PRESCALE_W_DEF = 8;
  localparam int unsigned GRACE_DEF      = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wdt32_if.sv
// Register-wrapper <-> watchdog core signals. rst_req exists only with WDT32_RESET_STAGE_EN.
interface wdt32_if;

  logic [31:0] WDLOAD;
  logic        WDEN;
  logic        WDOVCLR;
  logic [31:0] WDTMR;
  logic        WDOV;
`ifdef WDT32_RESET_STAGE_EN
  logic        rst_req;

  modport master (
    output WDLOAD, WDEN, WDOVCLR,
    input  WDTMR, WDOV, rst_req
  );

  modport slave (
    input  WDLOAD, WDEN, WDOVCLR,
    output WDTMR, WDOV, rst_req
  );
`else
  modport master (
    output WDLOAD, WDEN, WDOVCLR,
    input  WDTMR, WDOV
  );

  modport slave (
    input  WDLOAD, WDEN, WDOVCLR,
    output WDTMR, WDOV
  );
`endif

endinterface

// File: rtl/wdt32_prescaler.sv
// Divide-by-(PRESCALE+1) tick generator with synchronous clear.
module wdt32_prescaler #(
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned PRESCALE   = 0
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] Limit = PRESCALE_W'(PRESCALE);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wdt32_core.sv
// 32-bit down-counting watchdog with sticky overflow and edge-triggered kick.
// Define WDT32_RESET_STAGE_EN to add the grace counter and sticky rst_req output.
module wdt32_core
  import wdt32_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned PRESCALE   = 0,
  parameter int unsigned GRACE      = GRACE_DEF
) (
  input  logic    PCLK,
  input  logic    PRESETn,
  wdt32_if.slave  bus
);

  wdt32_state_e state_q;
  logic [31:0]  count_q;
  logic         wdov_q;
  logic         ovclr_q;
  logic         kick;
  logic         run_en;
  logic         tick;

  assign kick   = bus.WDOVCLR & ~ovclr_q;
  // Prescaler only advances while actually counting; any kick or stop restarts it.
  assign run_en = (state_q == ST_RUN) & bus.WDEN;

  wdt32_prescaler #(
    .PRESCALE_W (PRESCALE_W),
    .PRESCALE   (PRESCALE)
  ) u_prescaler (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (~run_en | kick),
    .en      (run_en),
    .tick    (tick)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wdov_q  <= 1'b0;
      ovclr_q <= 1'b0;
    end else begin
      ovclr_q <= bus.WDOVCLR;
      if (kick) begin
        wdov_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (bus.WDEN && (bus.WDLOAD != '0)) begin
            state_q <= ST_RUN;
            count_q <= bus.WDLOAD;
          end
        end
        ST_RUN: begin
          if (!bus.WDEN) begin
            state_q <= ST_IDLE;
          end else if (kick) begin
            count_q <= bus.WDLOAD;
          end else if (tick) begin
            if (count_q != '0) begin
              count_q <= count_q - 32'd1;
            end else begin
              // Expiry: flag and reload rather than wrapping.
              wdov_q  <= 1'b1;
              count_q <= bus.WDLOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.WDTMR = count_q;
  assign bus.WDOV  = wdov_q;

`ifdef WDT32_RESET_STAGE_EN
  localparam int unsigned GraceW = cnt_width(GRACE);

  logic [GraceW-1:0] grace_q;
  logic              rst_req_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      grace_q   <= '0;
      rst_req_q <= 1'b0;
    end else if (!wdov_q || kick) begin
      grace_q <= '0;
    end else if (!rst_req_q) begin
      if (grace_q == GraceW'(GRACE - 1)) begin
        rst_req_q <= 1'b1;
      end else begin
        grace_q <= grace_q + 1'b1;
      end
    end
  end

  assign bus.rst_req = rst_req_q;
`endif

endmodule

// File: tb/tb_wdt32_core.sv
// Directed bench for wdt32_core: vector table on a PRESCALE=0 instance plus hand sequences.
module tb_wdt32_core;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 PCLK = ~PCLK;

  wdt32_if bus0 ();
  wdt32_if bus3 ();

  wdt32_core #(.PRESCALE_W(8), .PRESCALE(0), .GRACE(16)) dut0 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus0)
  );

  wdt32_core #(.PRESCALE_W(8), .PRESCALE(3), .GRACE(16)) dut3 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus3)
  );

  typedef struct {
    logic [31:0] load;
    logic        en;
    logic        clr;
    logic [31:0] tmr;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] load, input logic en, input logic clr,
                     input logic [31:0] tmr, input logic ov);
    vec_t v;
    v.load = load; v.en = en; v.clr = clr; v.tmr = tmr; v.ov = ov;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive0(input logic [31:0] load, input logic en, input logic clr);
    bus0.WDLOAD = load; bus0.WDEN = en; bus0.WDOVCLR = clr;
  endtask

  logic [31:0] exp2 [13];

  initial begin
    drive0(32'd0, 1'b0, 1'b0);
    bus3.WDLOAD = 32'd0; bus3.WDEN = 1'b0; bus3.WDOVCLR = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_tmr0", bus0.WDTMR, 32'd0);
    chk("rst_ov0",  {31'd0, bus0.WDOV}, 32'd0);
    chk("rst_tmr3", bus3.WDTMR, 32'd0);
    PRESETn = 1'b1;

    // Basic countdown and periodic reload
    add(5, 1, 0, 5, 0); add(5, 1, 0, 4, 0); add(5, 1, 0, 3, 0); add(5, 1, 0, 2, 0);
    add(5, 1, 0, 1, 0); add(5, 1, 0, 0, 0); add(5, 1, 0, 5, 1); add(5, 1, 0, 4, 1);
    // Kick clears WDOV and reloads; new WDLOAD waits for the next reload
    add(5, 1, 1, 5, 0); add(3, 1, 0, 4, 0); add(3, 1, 0, 3, 0); add(3, 1, 0, 2, 0);
    add(3, 1, 0, 1, 0); add(3, 1, 0, 0, 0);
    // Kick on the expiry tick wins; held WDOVCLR does nothing further
    add(3, 1, 1, 3, 0); add(3, 1, 1, 2, 0); add(3, 1, 1, 1, 0); add(3, 1, 1, 0, 0);
    add(3, 1, 1, 3, 1); add(3, 1, 0, 2, 1);
    // Stop, then kick in IDLE clears WDOV only
    add(3, 0, 0, 2, 1); add(3, 0, 1, 2, 0);
    // WDEN drop at 7 freezes, re-rise reloads
    add(10, 1, 0, 10, 0); add(10, 1, 0, 9, 0); add(10, 1, 0, 8, 0); add(10, 1, 0, 7, 0);
    add(10, 0, 0, 7, 0);  add(10, 0, 0, 7, 0); add(10, 1, 0, 10, 0); add(10, 1, 0, 9, 0);
    // WDLOAD==0 keeps the core in IDLE
    add(0, 0, 0, 9, 0); add(0, 1, 0, 9, 0); add(0, 1, 0, 9, 0); add(0, 1, 0, 9, 0);

    foreach (vecs[i]) begin
      drive0(vecs[i].load, vecs[i].en, vecs[i].clr);
      step();
      chk($sformatf("vec%0d_tmr", i), bus0.WDTMR, vecs[i].tmr);
      chk($sformatf("vec%0d_ov", i), {31'd0, bus0.WDOV}, {31'd0, vecs[i].ov});
    end
    drive0(32'd0, 1'b0, 1'b0);

    // PRESCALE=3, WDLOAD=2: decrement every 4 cycles, WDOV after 12 cycles of RUN
    exp2 = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 2};
    bus3.WDLOAD = 32'd2; bus3.WDEN = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("pre3_tmr%0d", i), bus3.WDTMR, exp2[i]);
      chk($sformatf("pre3_ov%0d", i), {31'd0, bus3.WDOV}, (i == 12) ? 32'd1 : 32'd0);
    end
    bus3.WDEN = 1'b0;

    // Async reset mid-count with WDOV set and WDTMR=0x1234
    drive0(32'd1, 1'b1, 1'b0);
    step();
    chk("ar_tmr_a", bus0.WDTMR, 32'd1);
    bus0.WDLOAD = 32'h1234;
    step();
    chk("ar_tmr_b", bus0.WDTMR, 32'd0);
    step();
    chk("ar_tmr_c", bus0.WDTMR, 32'h1234);
    chk("ar_ov_c", {31'd0, bus0.WDOV}, 32'd1);
    PRESETn = 1'b0;
    #2;
    chk("ar_tmr", bus0.WDTMR, 32'd0);
    chk("ar_ov", {31'd0, bus0.WDOV}, 32'd0);
    chk("ar_tmr3", bus3.WDTMR, 32'd0);
    drive0(32'd0, 1'b0, 1'b0);
    #1;
    PRESETn = 1'b1;

`ifdef WDT32_RESET_STAGE_EN
    // Grace stage: no kick -> rst_req after 16 cycles; kick at 10 -> never
    for (int pass = 0; pass < 2; pass++) begin
      PRESETn = 1'b0;
      #1;
      PRESETn = 1'b1;
      drive0(32'd2, 1'b1, 1'b0);
      repeat (4) step();
      chk($sformatf("gr%0d_ov", pass), {31'd0, bus0.WDOV}, 32'd1);
      bus0.WDEN = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        bus0.WDOVCLR = (pass == 1 && k == 10);
        step();
        if (pass == 0) begin
          chk($sformatf("gr0_req%0d", k), {31'd0, bus0.rst_req}, (k >= 16) ? 32'd1 : 32'd0);
        end else begin
          chk($sformatf("gr1_req%0d", k), {31'd0, bus0.rst_req}, 32'd0);
          chk($sformatf("gr1_ov%0d", k), {31'd0, bus0.WDOV}, (k >= 10) ? 32'd0 : 32'd1);
        end
      end
      drive0(32'd0, 1'b0, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
